// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: word RAM behind a read/write/waitrequest bus with programmable stall; define MEM_LFSR_WAIT_EN for LFSR-jittered extra wait states
module avalon_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t      state_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] word_d;
  logic        hit_d;
  logic [AW-1:0] idx_d, idx_q;
  logic [4:0]  cnt_d, cnt_q;
  logic        wr_q, hit_q, wait_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q, rd_q;
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'h0;
  end
  assign word_d = 30'((address - ADDR_BASE) >> 2);
  assign hit_d  = address >= ADDR_BASE && {2'b00, word_d} < 32'(DEPTH_WORDS);
  assign idx_d  = word_d[AW-1:0];
`ifdef MEM_LFSR_WAIT_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk)
    if (reset) lfsr_q <= 8'hA5;
    else if (state_q == IDLE && (read || write))
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cnt_d = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
  assign cnt_d = 5'(WAIT_CYCLES);
`endif
  // read+write together is serviced as a write, so readdata is only loaded for pure reads
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= 1'b1;
      rd_q    <= 32'h0;
      cnt_q   <= 5'd0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      be_q    <= 4'h0;
      wd_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (read || write) begin
          wr_q    <= write;
          hit_q   <= hit_d;
          idx_q   <= idx_d;
          be_q    <= byteenable;
          wd_q    <= writedata;
          cnt_q   <= cnt_d;
          if (!write) rd_q <= hit_d ? mem[idx_d] : 32'h0;
          state_q <= cnt_d == 5'd0 ? ACK : BUSY;
          wait_q  <= cnt_d != 5'd0;
        end
        BUSY: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= ACK;
            wait_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          wait_q  <= 1'b1;
        end
      endcase
    end
  // the write lands at the ACK edge, so a read sampled in the following IDLE sees it
  always_ff @(posedge clk)
    if (!reset && state_q == ACK && wr_q && hit_q)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
  always @(posedge clk)
    if (!reset && state_q == IDLE)
      assert (!(read && write)) else $error("avalon_mem_responder: read and write both asserted");
  assign waitrequest = wait_q;
  assign readdata    = rd_q;
endmodule
